// File: rtl/ddc_phase_sequencer_pkg.sv
// ddc_phase_sequencer_pkg
// Shared definitions for the DDC phase sequencer slice:
//   - seq_state_e      : sequencer FSM state encoding
//   - DDS_LATENCY/DDC_LATENCY : pipeline latencies that make up the default settle time
//   - ADDR_*           : field positions inside the 4-bit shadow write address
//   - SEL_*            : select values for the pinc/poff word of a channel
package ddc_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2
  } seq_state_e;

  localparam int DDS_LATENCY = 8;
  localparam int DDC_LATENCY = 6;

  localparam int ADDR_W       = 4;
  localparam int ADDR_SEL_BIT = 0;
  localparam int ADDR_CH_LSB  = 1;
  localparam int ADDR_CH_MSB  = 3;

  localparam int SEL_PINC = 0;
  localparam int SEL_POFF = 1;

endpackage

// File: rtl/ddc_phase_sequencer_if.sv
// ddc_phase_sequencer_if
// Bundles the shadow-write/commit control inputs and the per-channel phase
// outputs of the sequencer.
//   master modport : drives wr_en/wr_addr/wr_data/commit/commit_resync,
//                    observes phase tdata/tvalid, resync, busy, phase_ready
//   slave modport  : the sequencer side (directions reversed)
interface ddc_phase_sequencer_if
  import ddc_phase_sequencer_pkg::*;
#(
  parameter int N_CH = 8
);

  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [31:0]          wr_data;
  logic                 commit;
  logic                 commit_resync;
  logic [N_CH*64-1:0]   m_axis_phase_tdata;
  logic [N_CH-1:0]      m_axis_phase_tvalid;
  logic                 resync;
  logic                 busy;
  logic                 phase_ready;

  modport master (
    output wr_en, wr_addr, wr_data, commit, commit_resync,
    input  m_axis_phase_tdata, m_axis_phase_tvalid, resync, busy, phase_ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, commit_resync,
    output m_axis_phase_tdata, m_axis_phase_tvalid, resync, busy, phase_ready
  );

endinterface

// File: rtl/ddc_phase_sequencer_phase_reg_bank.sv
// phase_reg_bank
// Shadow and active phase registers for N_CH channels (pinc and poff each).
//   clk, reset   : clock and synchronous active-high reset
//   wr_en/addr/data : shadow write port; channels >= N_CH are ignored
//   snapshot     : copy every shadow into its active register
//   active_flat  : per channel k, [64k+63:64k] = {poff, pinc} from active regs
module phase_reg_bank
  import ddc_phase_sequencer_pkg::*;
#(
  parameter int N_CH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [31:0]         wr_data,
  input  logic                snapshot,
  output logic [N_CH*64-1:0]  active_flat
);

  localparam logic [4:0] CH_LIMIT = 5'(N_CH);

  logic [31:0] shadow_q [N_CH][2];
  logic [31:0] shadow_d [N_CH][2];
  logic [31:0] active_q [N_CH][2];
  logic [31:0] active_d [N_CH][2];

  logic [4:0] wr_ch;
  logic       wr_sel;
  logic       wr_hit;

  // Channel index is widened so the out-of-range test works for any N_CH.
  assign wr_ch  = 5'(wr_addr[ADDR_CH_MSB:ADDR_CH_LSB]);
  assign wr_sel = wr_addr[ADDR_SEL_BIT];
  assign wr_hit = wr_en && (wr_ch < CH_LIMIT);

  // Snapshot reads shadow_q, so a write landing in the same cycle is not seen.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (snapshot) begin
      active_d = shadow_q;
    end
    for (int k = 0; k < N_CH; k++) begin
      if (wr_hit && (wr_ch == 5'(k))) begin
        shadow_d[k][wr_sel] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_flat
    assign active_flat[k*64 +: 64] = {active_q[k][SEL_POFF], active_q[k][SEL_PINC]};
  end

endmodule

// File: rtl/ddc_phase_sequencer.sv
// ddc_phase_sequencer
// Pushes committed phase increments/offsets to N_CH DDC channels one channel
// per clock, optionally with a shared DDS resync, then waits SETTLE_CYC clocks
// for the DDS+DDC pipelines before declaring phase_ready. Commits that arrive
// while a sequence is running coalesce into one follow-up sequence.
//   s_axis_aclk : single clock, rising edge
//   reset       : synchronous active-high reset
//   bus         : slave side of ddc_phase_sequencer_if (writes, commit, outputs)
module ddc_phase_sequencer
  import ddc_phase_sequencer_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int SETTLE_CYC = DDS_LATENCY + DDC_LATENCY
) (
  input  logic s_axis_aclk,
  input  logic reset,
  ddc_phase_sequencer_if.slave bus
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  seq_state_e       state_q, state_d;
  logic [CH_W-1:0]  ch_idx_q, ch_idx_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             pending_q, pending_d;
  logic             pending_resync_q, pending_resync_d;
  logic             resync_q, resync_d;
  logic             phase_ready_q, phase_ready_d;
  logic             snapshot;
  logic [N_CH-1:0]  tvalid;

  phase_reg_bank #(
    .N_CH(N_CH)
  ) u_phase_reg_bank (
    .clk        (s_axis_aclk),
    .reset      (reset),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .wr_data    (bus.wr_data),
    .snapshot   (snapshot),
    .active_flat(bus.m_axis_phase_tdata)
  );

  always_ff @(posedge s_axis_aclk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      ch_idx_q         <= '0;
      settle_cnt_q     <= '0;
      pending_q        <= 1'b0;
      pending_resync_q <= 1'b0;
      resync_q         <= 1'b0;
      phase_ready_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      ch_idx_q         <= ch_idx_d;
      settle_cnt_q     <= settle_cnt_d;
      pending_q        <= pending_d;
      pending_resync_q <= pending_resync_d;
      resync_q         <= resync_d;
      phase_ready_q    <= phase_ready_d;
    end
  end

  // Next-state logic. A pending commit is only acted on from IDLE, which
  // gives one IDLE cycle between back-to-back sequences.
  always_comb begin
    state_d          = state_q;
    ch_idx_d         = ch_idx_q;
    settle_cnt_d     = settle_cnt_q;
    pending_d        = pending_q;
    pending_resync_d = pending_resync_q;
    resync_d         = resync_q;
    phase_ready_d    = phase_ready_q;
    snapshot         = 1'b0;

    if ((state_q != ST_IDLE) && bus.commit) begin
      pending_d        = 1'b1;
      pending_resync_d = pending_resync_q | bus.commit_resync;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.commit || pending_q) begin
          snapshot         = 1'b1;
          state_d          = ST_LOAD;
          ch_idx_d         = '0;
          resync_d         = (bus.commit & bus.commit_resync) | pending_resync_q;
          pending_d        = 1'b0;
          pending_resync_d = 1'b0;
          phase_ready_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ch_idx_q == CH_W'(N_CH - 1)) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = CNT_W'(SETTLE_CYC - 1);
        end else begin
          ch_idx_d = ch_idx_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d       = ST_IDLE;
          phase_ready_d = ~pending_d;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One-hot channel strobe while loading.
  always_comb begin
    tvalid = '0;
    if (state_q == ST_LOAD) begin
      for (int k = 0; k < N_CH; k++) begin
        if (ch_idx_q == CH_W'(k)) begin
          tvalid[k] = 1'b1;
        end
      end
    end
  end

  assign bus.m_axis_phase_tvalid = tvalid;
  assign bus.resync              = (state_q == ST_LOAD) && resync_q;
  assign bus.busy                = (state_q != ST_IDLE);
  assign bus.phase_ready         = phase_ready_q;

endmodule

// File: tb/tb_ddc_phase_sequencer.sv
// tb_ddc_phase_sequencer
// Directed and random stimulus against a time-window reference model of the
// sequencer (N_CH=8, SETTLE_CYC=14), plus a small N_CH=4 instance for the
// out-of-range address case.
module tb_ddc_phase_sequencer;

  localparam int N8 = 8;
  localparam int S8 = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;

  ddc_phase_sequencer_if #(.N_CH(8)) bus8 ();
  ddc_phase_sequencer_if #(.N_CH(4)) bus4 ();

  ddc_phase_sequencer #(.N_CH(8), .SETTLE_CYC(14)) dut (
    .s_axis_aclk(clk),
    .reset      (rst),
    .bus        (bus8)
  );

  ddc_phase_sequencer #(.N_CH(4), .SETTLE_CYC(2)) dut4 (
    .s_axis_aclk(clk),
    .reset      (rst),
    .bus        (bus4)
  );

  always #5 clk = ~clk;

  // Reference model: a sequence is a time window starting at seq_start;
  // channel k strobes at seq_start+k and the block is busy for N8+S8 cycles.
  logic [31:0] m_shadow [8][2];
  logic [31:0] m_active [8][2];
  int cyc;
  bit seq_on;
  int seq_start;
  bit pending;
  bit pend_res;
  bit cur_res;
  bit ready;

  task automatic modelReset();
    m_shadow = '{default: '0};
    m_active = '{default: '0};
    seq_on   = 1'b0;
    pending  = 1'b0;
    pend_res = 1'b0;
    cur_res  = 1'b0;
    ready    = 1'b0;
  endtask

  task automatic modelStep(input bit r, input bit we, input logic [3:0] wa,
                           input logic [31:0] wd, input bit c, input bit cr);
    int last;
    bit in_seq;
    last   = seq_start + N8 + S8 - 1;
    in_seq = seq_on && (cyc >= seq_start) && (cyc <= last);
    if (r) begin
      modelReset();
    end else begin
      if (!in_seq && (c || pending)) begin
        m_active  = m_shadow;
        cur_res   = (c && cr) || pend_res;
        pending   = 1'b0;
        pend_res  = 1'b0;
        ready     = 1'b0;
        seq_on    = 1'b1;
        seq_start = cyc + 1;
      end else if (in_seq) begin
        if (c) begin
          pending  = 1'b1;
          pend_res = pend_res | cr;
        end
        if ((cyc == last) && !pending) ready = 1'b1;
      end
      if (we && (int'(wa[3:1]) < N8)) m_shadow[wa[3:1]][wa[0]] = wd;
    end
    cyc++;
  endtask

  task automatic checkOutput();
    bit load;
    bit in_seq;
    logic [7:0]   exp_tv;
    logic [511:0] exp_td;
    load   = seq_on && (cyc >= seq_start) && (cyc < seq_start + N8);
    in_seq = seq_on && (cyc >= seq_start) && (cyc < seq_start + N8 + S8);
    exp_tv = load ? 8'(1 << (cyc - seq_start)) : 8'h00;
    for (int k = 0; k < N8; k++) exp_td[k*64 +: 64] = {m_active[k][1], m_active[k][0]};

    checks++;
    assert (bus8.m_axis_phase_tvalid === exp_tv) else begin
      errors++;
      $error("FAIL tvalid cyc=%0d observed=%h expected=%h", cyc, bus8.m_axis_phase_tvalid, exp_tv);
    end
    checks++;
    assert (bus8.resync === (load && cur_res)) else begin
      errors++;
      $error("FAIL resync cyc=%0d observed=%b expected=%b", cyc, bus8.resync, load && cur_res);
    end
    checks++;
    assert (bus8.busy === in_seq) else begin
      errors++;
      $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, bus8.busy, in_seq);
    end
    checks++;
    assert (bus8.phase_ready === ready) else begin
      errors++;
      $error("FAIL phase_ready cyc=%0d observed=%b expected=%b", cyc, bus8.phase_ready, ready);
    end
    checks++;
    assert (bus8.m_axis_phase_tdata === exp_td) else begin
      errors++;
      $error("FAIL tdata cyc=%0d observed=%h expected=%h", cyc, bus8.m_axis_phase_tdata, exp_td);
    end
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock: drive inputs, check this cycle's outputs at the falling edge,
  // then advance the model across the rising edge.
  task automatic applyStimulus(input bit r, input bit we, input logic [3:0] wa,
                               input logic [31:0] wd, input bit c, input bit cr);
    rst                = r;
    bus8.wr_en         = we;
    bus8.wr_addr       = wa;
    bus8.wr_data       = wd;
    bus8.commit        = c;
    bus8.commit_resync = cr;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelStep(r, we, wa, wd, c, cr);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic step4(input bit r, input bit we, input logic [3:0] wa,
                       input logic [31:0] wd, input bit c);
    rst                = r;
    bus4.wr_en         = we;
    bus4.wr_addr       = wa;
    bus4.wr_data       = wd;
    bus4.commit        = c;
    bus4.commit_resync = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus8.wr_en = 1'b0; bus8.wr_addr = '0; bus8.wr_data = '0;
    bus8.commit = 1'b0; bus8.commit_resync = 1'b0;
    bus4.wr_en = 1'b0; bus4.wr_addr = '0; bus4.wr_data = '0;
    bus4.commit = 1'b0; bus4.commit_resync = 1'b0;
    cyc = 0;
    seq_start = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);

    // Basic sequence with a known channel 0 value.
    $display("[TB] basic commit");
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0100_0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h1, 32'h8000_0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    checkVal("slice0_after_commit", bus8.m_axis_phase_tdata[63:0], 64'h8000_0000_0100_0000);
    checkVal("tvalid0_at_T1", 64'(bus8.m_axis_phase_tvalid), 64'h01);
    idle(30);

    // Resync on, then resync off.
    $display("[TB] resync commits");
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
    idle(25);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    idle(25);

    // Coalesced commits during LOAD and SETTLE, second one requesting resync.
    $display("[TB] coalesced commits");
    applyStimulus(1'b0, 1'b1, 4'h6, 32'h5555_0001, 1'b1, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b1, 4'h6, 32'h5555_0002, 1'b1, 1'b0);
    idle(6);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
    idle(50);

    // Shadow write during LOAD must not disturb the active channel 2 value.
    $display("[TB] write during load");
    applyStimulus(1'b0, 1'b1, 4'h4, 32'hAAAA_0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h5, 32'h0000_0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    idle(25);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    idle(4);
    applyStimulus(1'b0, 1'b1, 4'h4, 32'h0000_1234, 1'b0, 1'b0);
    idle(30);
    checkVal("slice2_held", bus8.m_axis_phase_tdata[191:128], 64'h0000_0000_AAAA_0000);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    checkVal("slice2_updated", bus8.m_axis_phase_tdata[191:128], 64'h0000_0000_0000_1234);
    idle(25);

    // Reset in the middle of LOAD, then a fresh sequence.
    $display("[TB] reset mid-load");
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
    idle(3);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    checkVal("all_outputs_after_reset",
             {bus8.m_axis_phase_tvalid, 52'(bus8.m_axis_phase_tdata != '0),
              bus8.resync, bus8.busy, bus8.phase_ready, 1'b0}, 64'h0);
    idle(5);
    applyStimulus(1'b0, 1'b1, 4'h3, 32'hDEAD_BEEF, 1'b1, 1'b0);
    idle(25);

    // Random traffic.
    $display("[TB] random traffic");
    for (int i = 0; i < 700; i++) begin
      applyStimulus(($urandom_range(0, 249) == 0),
                    ($urandom_range(0, 2) == 0),
                    4'($urandom_range(0, 15)),
                    $urandom(),
                    ($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 1)));
    end
    idle(40);

    // N_CH=4 instance: addresses of channels 4..7 must be ignored.
    $display("[TB] out-of-range addresses");
    bus8.commit = 1'b0;
    bus8.wr_en  = 1'b0;
    step4(1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
    step4(1'b0, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0);
    step4(1'b0, 1'b1, 4'h9, 32'h1111_1111, 1'b0);
    step4(1'b0, 1'b1, 4'hE, 32'h2222_2222, 1'b0);
    step4(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) step4(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    checkVal("n4_tdata_lo", bus4.m_axis_phase_tdata[63:0], 64'h0);
    checkVal("n4_tdata_ch3", bus4.m_axis_phase_tdata[255:192], 64'h0);
    checkVal("n4_ready", 64'(bus4.phase_ready), 64'h1);
    step4(1'b0, 1'b1, 4'h6, 32'h0000_BEEF, 1'b0);
    step4(1'b0, 1'b1, 4'h7, 32'h0000_CAFE, 1'b0);
    step4(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    checkVal("n4_tvalid_T1", 64'(bus4.m_axis_phase_tvalid), 64'h1);
    checkVal("n4_slice3", bus4.m_axis_phase_tdata[255:192], 64'h0000_CAFE_0000_BEEF);
    for (int i = 0; i < 6; i++) step4(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    checkVal("n4_ready_T7", 64'(bus4.phase_ready), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
